// File: rtl/mc14500_fetch.sv
// mc14500_fetch: instruction fetch unit with PC, jumps, return stack and SKZ skip
// Ports:
//   clk, rst_n                  clock and synchronous active-low reset
//   rom_read, rom_address       ROM read strobe and address (address is the PC)
//   rom_data                    ROM read data, combinationally valid while rom_read
//   instr, instr_pc             fetched word and the address it came from
//   instr_valid, instr_ready    output handshake to the decoder
//   jmp, jmp_link, jmp_target   redirect, optionally pushing instr_pc+1
//   rtn                         pop the return stack into the PC
//   skz                         discard the next sequential instruction
//   stack_overflow/underflow    sticky stack error flags
module mc14500_fetch #(
    parameter int ADDR_W      = 8,
    parameter int WORD        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_read,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [WORD-1:0]   rom_data,
    output logic [WORD-1:0]   instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jmp,
    input  logic              jmp_link,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              rtn,
    input  logic              skz,
    output logic              stack_overflow,
    output logic              stack_underflow
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int IX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic              fetch, acc, full, empty;
    logic [IX_W-1:0]   top, free;
    assign acc         = instr_valid & instr_ready;
    assign fetch       = rst_n & (~instr_valid | instr_ready);
    assign rom_read    = fetch;
    assign rom_address = pc;
    assign full        = sp == SP_W'(STACK_DEPTH);
    assign empty       = sp == '0;
    assign top         = IX_W'(sp - 1'b1);
    assign free        = IX_W'(sp);
    // Redirects drop the word fetched in the same cycle, giving one bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc              <= '0;
            sp              <= '0;
            instr           <= '0;
            instr_pc        <= '0;
            instr_valid     <= 1'b0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else if (fetch) begin
            if (acc && jmp) begin
                pc          <= jmp_target;
                instr_valid <= 1'b0;
                if (jmp_link) begin
                    if (full) begin
                        stack_overflow <= 1'b1;
                    end else begin
                        stack[free] <= instr_pc + 1'b1;
                        sp          <= sp + 1'b1;
                    end
                end
            end else if (acc && rtn) begin
                instr_valid <= 1'b0;
                if (empty) begin
                    pc              <= '0;
                    stack_underflow <= 1'b1;
                end else begin
                    pc <= stack[top];
                    sp <= sp - 1'b1;
                end
            end else if (acc && skz) begin
                instr_valid <= 1'b0;
                pc          <= pc + 1'b1;
            end else begin
                instr       <= rom_data;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + 1'b1;
            end
        end
    end
endmodule

// File: doc/mc14500_fetch.md
# mc14500_fetch

Instruction fetch unit for the MC14500B core. It drives the program ROM's read/address port, captures the returned instruction word into a one-entry output register, and hands it to the decoder over a valid/ready handshake. It owns the program counter, including jumps, a hardware return stack, and the SKZ skip.

## Interface
- `ADDR_W`, 8: program address width; must equal the ROM `SIZE_LOG`.
- `WORD`, 8: instruction width; must equal the ROM `WORD`.
- `STACK_DEPTH`, 4: number of return-stack entries, ≥1.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rom_read`  out  1  ROM read strobe.
- `rom_address`  out  ADDR_W  ROM address; always equals `pc`.
- `rom_data`  in  WORD  ROM read data; valid combinationally in the cycle `rom_read` is high.
- `instr`  out  WORD  fetched instruction.
- `instr_pc`  out  ADDR_W  address `instr` was fetched from.
- `instr_valid`  out  1  `instr` and `instr_pc` are valid.
- `instr_ready`  in  1  decoder accepts `instr` this cycle.
- `jmp`  in  1  redirect to `jmp_target`; sampled only on accept.
- `jmp_link`  in  1  with `jmp`: push `instr_pc+1` onto the return stack.
- `jmp_target`  in  ADDR_W  jump destination.
- `rtn`  in  1  pop the return stack into `pc`; sampled only on accept.
- `skz`  in  1  discard the next sequential instruction; sampled only on accept.
- `stack_overflow`  out  1  sticky flag: a push was attempted while full.
- `stack_underflow`  out  1  sticky flag: a pop was attempted while empty.

## Operation
- Internal state: `pc`, the output register (`instr`, `instr_pc`, `instr_valid`), the stack array, and the stack pointer `sp` (0..STACK_DEPTH).
- Accept: `acc = instr_valid & instr_ready`.
- Fetch: `fetch = rst_n & (~instr_valid | instr_ready)`; `rom_read = fetch`.
- Control inputs `jmp`/`rtn`/`skz` are ignored unless `acc`.
- Priority when several are high: `jmp` > `rtn` > `skz`. Lower-priority requests are dropped, including their stack side effects.
- Clock edge with `fetch` and no redirect:
  - `instr <= rom_data`, `instr_pc <= pc`, `instr_valid <= 1`, `pc <= pc+1`.
- Clock edge with `~fetch`: all state holds.
- `acc & jmp`:
  - `pc <= jmp_target`, `instr_valid <= 0`; the word fetched this cycle is discarded.
  - If `jmp_link`: push `instr_pc+1` (mod 2^ADDR_W).
  - Push when `sp==STACK_DEPTH`: stack unchanged, `stack_overflow <= 1`.
- `acc & rtn` (no `jmp`):
  - Pop: `pc <= stack[sp-1]`, `sp <= sp-1`, `instr_valid <= 0`.
  - Pop when `sp==0`: `pc <= 0`, `stack_underflow <= 1`.
- `acc & skz` (no `jmp`/`rtn`):
  - The word fetched this cycle is at `instr_pc+1` (invariant: `pc == instr_pc+1` whenever `instr_valid`).
  - That word is discarded: `instr_valid <= 0`, `pc <= pc+1`.
- `pc` arithmetic is modulo 2^ADDR_W: address 2^ADDR_W−1 is followed by 0. The same applies to the pushed `instr_pc+1`.
- The block never asserts a ROM write.

## Timing
- Reset (`rst_n` low at an edge):
  - `pc=0`, `sp=0`, `instr=0`, `instr_pc=0`, `instr_valid=0`, `stack_overflow=0`, `stack_underflow=0`.
  - `rom_read` is 0 combinationally while `rst_n` is low.
  - Reset mid-operation discards the output register and the stack.
- First instruction (address 0) is valid in the cycle after reset deasserts (1-cycle fetch latency).
- Throughput: with `instr_ready` held high, one instruction per cycle.
- `jmp`/`rtn`/`skz` each cost exactly one bubble cycle (`instr_valid=0`); the target or skipped-to instruction is valid on the following cycle.
- Backpressure: `instr_valid & ~instr_ready` holds `instr`, `instr_pc`, `pc` and `rom_read=0` stable for any number of cycles.
- No combinational path from `rom_data` to any output. `rom_read` depends combinationally on `instr_ready`, `instr_valid` and `rst_n` only.

## Test plan
- Reset release, `instr_ready=1`, ROM[k]=k+0x10 → `instr_pc` 0,1,2,… on consecutive cycles with `instr` 0x10,0x11,0x12…; all flags stay 0.
- Hold `instr_ready=0` for 5 cycles while `instr_pc=3` → `instr`/`instr_pc`/`rom_address` stable and `rom_read=0`; on release, the next accepted instruction is from address 4.
- Accept at `instr_pc=5` with `jmp=1`, `jmp_link=1`, target 0x40 → one bubble, then `instr_pc=0x40`. Later `rtn` → one bubble, then `instr_pc=6`.
- Accept at `instr_pc=9` with `skz=1` → one bubble, then `instr_pc=11`. Separately, `jmp`+`rtn`+`skz` together with target 0x20 → `instr_pc=0x20` and `sp` unchanged.
- Five linked jumps with STACK_DEPTH=4 → `stack_overflow=1`. Then five `rtn`: the first four return in LIFO order, the fifth goes to `pc=0` with `stack_underflow=1`.
- Sequential fetch from 0xFE (ADDR_W=8) → `instr_pc` 0xFE, 0xFF, 0x00. Assert `rst_n=0` mid-stream for one edge → `instr_valid=0` and a restart from 0.
